// File: rtl/fmc_adc_pkg.sv
// Shared types and constants for the FMC ADC frame decoder.
// Holds the FSM state type, channel/frame geometry and the per-channel sample bundle.
package fmc_adc_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } t_fr_state;

  localparam int c_ADC_NCHAN   = 4;
  localparam int c_FRAME_SLOTS = 8;
  localparam int c_SAMPLE_W    = 14;

  typedef logic [c_ADC_NCHAN-1:0][c_SAMPLE_W+1:0] t_sample_array;

endpackage

// File: rtl/fmc_adc_lane_deser.sv
// Per-channel odd/even lane shift registers with bit interleave.
// Produces the 14-bit sample left-aligned in 16 bits; the pad pair is dropped.
module fmc_adc_lane_deser
  import fmc_adc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  odd_i,
  input  logic                  even_i,
  output logic [c_SAMPLE_W+1:0] sample_o
);

  logic [c_FRAME_SLOTS-1:0] odd_sr_q, odd_sr_d;
  logic [c_FRAME_SLOTS-1:0] even_sr_q, even_sr_d;

  always_comb begin
    odd_sr_d  = {odd_sr_q[c_FRAME_SLOTS-2:0], odd_i};
    even_sr_d = {even_sr_q[c_FRAME_SLOTS-2:0], even_i};
    // Slot 0 (LSB) holds the pad pair; it falls off the bottom of the sample.
    sample_o = '0;
    for (int i = 1; i < c_FRAME_SLOTS; i++) begin
      sample_o[2*i+1] = odd_sr_q[i];
      sample_o[2*i]   = even_sr_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      odd_sr_q  <= '0;
      even_sr_q <= '0;
    end else begin
      odd_sr_q  <= odd_sr_d;
      even_sr_q <= even_sr_d;
    end
  end

endmodule

// File: rtl/fmc_adc_frame_decoder.sv
// LTC2174-style 2-lane serial frame decoder: FR hunt/lock FSM, sample
// assembly for four channels and a saturating frame-error counter.
module fmc_adc_frame_decoder
  import fmc_adc_pkg::*;
#(
  parameter int unsigned g_LOCK_FRAMES = 4,
  parameter int unsigned g_UNLOCK_ERRS = 2,
  parameter logic [7:0]  g_FR_PATTERN  = 8'hF0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   fr_i,
  input  logic [c_ADC_NCHAN-1:0] lane_odd_i,
  input  logic [c_ADC_NCHAN-1:0] lane_even_i,
  input  logic                   clr_cnt_i,
  output logic [63:0]            data_o,
  output logic                   valid_o,
  output logic                   locked_o,
  output logic                   frame_err_o,
  output logic [15:0]            err_cnt_o
);

  t_fr_state     state_q, state_d;
  logic [7:0]    fr_sr_q, fr_sr_d;
  logic [2:0]    slot_q, slot_d;
  logic [7:0]    good_cnt_q, good_cnt_d;
  logic [7:0]    err_run_q, err_run_d;
  t_sample_array data_q, data_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          frame_err_q, frame_err_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  t_sample_array samples;
  logic          fr_match;
  logic          boundary;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar c = 0; c < c_ADC_NCHAN; c++) begin : g_deser
    fmc_adc_lane_deser u_deser (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .odd_i    (lane_odd_i[c]),
      .even_i   (lane_even_i[c]),
      .sample_o (samples[c])
    );
  end

  always_comb begin
    fr_sr_d     = {fr_sr_q[6:0], fr_i};
    slot_d      = slot_q + 3'd1;
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    err_run_d   = err_run_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    // Decisions use the registers after the edge that shifted in the last slot.
    fr_match    = (fr_sr_q == g_FR_PATTERN);
    boundary    = (slot_q == 3'(c_FRAME_SLOTS - 1));

    if (!en_i) begin
      state_d    = HUNT;
      good_cnt_d = '0;
      err_run_d  = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (fr_match) begin
            slot_d     = '0;
            good_cnt_d = 8'd1;
            state_d    = CHECK;
          end
        end
        CHECK: begin
          if (boundary) begin
            if (fr_match) begin
              good_cnt_d = good_cnt_q + 8'd1;
              if (good_cnt_d == 8'(g_LOCK_FRAMES)) begin
                state_d   = LOCKED;
                err_run_d = '0;
              end
            end else begin
              state_d    = HUNT;
              good_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (fr_match) begin
              data_d    = samples;
              valid_d   = 1'b1;
              err_run_d = '0;
            end else begin
              frame_err_d = 1'b1;
              err_cnt_d   = sat_inc(err_cnt_q);
              err_run_d   = err_run_q + 8'd1;
              if (err_run_d == 8'(g_UNLOCK_ERRS)) begin
                state_d    = HUNT;
                err_run_d  = '0;
                good_cnt_d = '0;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clr_cnt_i) err_cnt_d = '0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HUNT;
      fr_sr_q     <= '0;
      slot_q      <= '0;
      good_cnt_q  <= '0;
      err_run_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fr_sr_q     <= fr_sr_d;
      slot_q      <= slot_d;
      good_cnt_q  <= good_cnt_d;
      err_run_q   <= err_run_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign locked_o    = locked_q;
  assign frame_err_o = frame_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
